// File: rtl/bubble_pipe.sv
// bubble_pipe: valid/ready register pipeline with bubble collapse.
// Each stage can accept a new item whenever it is empty, even while
// downstream stalls. With REG_READY=0 the upstream ready is the end of a
// combinational chain from m_ready. With REG_READY=1 a one-entry skid
// register sits in front of stage 0 so that s_ready comes straight from a
// flop. count tracks every item held (stages plus skid).
module bubble_pipe #(
  parameter  int DATA_WIDTH = 8,
  parameter  int STAGES     = 3,
  parameter  int REG_READY  = 0,
  localparam int CAP        = STAGES + REG_READY,
  localparam int CW         = $clog2(CAP + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full
);

  localparam logic [CW-1:0] CAP_C = CW'(CAP);

  logic [STAGES-1:0]     valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q [STAGES];
  logic [DATA_WIDTH-1:0] data_d [STAGES];
  logic [CW-1:0]         count_q, count_d;

  // stage_rdy[i] is r_i; stage_rdy[STAGES] is the downstream ready.
  logic [STAGES:0]       stage_rdy;

  // Item offered to stage 0 (from the skid or straight from s_data).
  logic                  feed_valid;
  logic [DATA_WIDTH-1:0] feed_data;

  logic                  in_xfer;
  logic                  out_xfer;

  // Ready chain: a stage is ready if the next one is ready or it is empty.
  always_comb begin
    stage_rdy[STAGES] = m_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      stage_rdy[i] = stage_rdy[i+1] | ~valid_q[i];
    end
  end

  if (REG_READY == 0) begin : g_comb_ready
    // Upstream sees the raw chain; nothing is accepted during rst or flush.
    assign s_ready    = stage_rdy[0] & ~flush & ~rst;
    assign feed_valid = s_valid & s_ready;
    assign feed_data  = s_data;
  end else begin : g_skid
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

    // Ready depends only on the skid flop, breaking the m_ready chain.
    assign s_ready    = ~skid_valid_q & ~flush & ~rst;
    // A held skid entry has priority; otherwise s_data bypasses the skid.
    assign feed_valid = skid_valid_q | (s_valid & s_ready);
    assign feed_data  = skid_valid_q ? skid_data_q : s_data;

    // Skid next state: drain into stage 0 when it frees, capture on a stall.
    always_comb begin
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (skid_valid_q) begin
        if (stage_rdy[0]) begin
          skid_valid_d = 1'b0;
        end
      end else if (s_valid && s_ready && !stage_rdy[0]) begin
        skid_valid_d = 1'b1;
        skid_data_d  = s_data;
      end
    end

    // Skid register; flush drops the entry but leaves its payload alone.
    always_ff @(posedge clk) begin
      if (rst) begin
        skid_valid_q <= 1'b0;
        skid_data_q  <= '0;
      end else if (flush) begin
        skid_valid_q <= 1'b0;
      end else begin
        skid_valid_q <= skid_valid_d;
        skid_data_q  <= skid_data_d;
      end
    end
  end

  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;

  // Stage next state: a ready stage takes its upstream valid; data moves
  // only with a real item so bubbles leave payloads untouched.
  // NOTE: every variable of a combinational block gets a default on entry;
  // a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (stage_rdy[0]) begin
      valid_d[0] = feed_valid;
      if (feed_valid) begin
        data_d[0] = feed_data;
      end
    end
    for (int i = 1; i < STAGES; i++) begin
      if (stage_rdy[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          data_d[i] = data_q[i-1];
        end
      end
    end
  end

  // Occupancy: +1 on input-only, -1 on output-only, hold otherwise.
  always_comb begin
    count_d = count_q;
    if (in_xfer && !out_xfer) begin
      count_d = count_q + 1'b1;
    end else if (!in_xfer && out_xfer) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pipeline state. rst clears everything including payloads; flush clears
  // only the bookkeeping so payload registers keep their last contents.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
      // NOTE: the payload array is reset element by element; it is a bank
      // of flops, not a RAM, so a reset value costs nothing special.
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // Output is suppressed in a rst or flush cycle so nothing leaves.
  assign m_valid = valid_q[STAGES-1] & ~flush & ~rst;
  assign m_data  = data_q[STAGES-1];
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CAP_C);

endmodule

// File: tb/tb_bubble_pipe.sv
// Directed bench for bubble_pipe: one instance per REG_READY mode, each
// with its own handshake signals and a shared clock and reset.
module tb_bubble_pipe;

  logic       clk;
  logic       rst;
  logic [1:0] flush;
  logic [1:0] s_valid;
  logic [1:0] s_ready;
  logic [1:0] m_valid;
  logic [1:0] m_ready;
  logic [1:0] empty;
  logic [1:0] full;
  logic [7:0] s_data [2];
  logic [7:0] m_data [2];
  logic [1:0] count0;
  logic [2:0] count1;

  int total = 0;
  int bad   = 0;

  bubble_pipe #(.DATA_WIDTH(8), .STAGES(3), .REG_READY(0)) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush[0]),
    .s_valid (s_valid[0]),
    .s_ready (s_ready[0]),
    .s_data  (s_data[0]),
    .m_valid (m_valid[0]),
    .m_ready (m_ready[0]),
    .m_data  (m_data[0]),
    .count   (count0),
    .empty   (empty[0]),
    .full    (full[0])
  );

  bubble_pipe #(.DATA_WIDTH(8), .STAGES(3), .REG_READY(1)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush[1]),
    .s_valid (s_valid[1]),
    .s_ready (s_ready[1]),
    .s_data  (s_data[1]),
    .m_valid (m_valid[1]),
    .m_ready (m_ready[1]),
    .m_data  (m_data[1]),
    .count   (count1),
    .empty   (empty[1]),
    .full    (full[1])
  );

  always #5 clk = ~clk;

  function automatic int cnt(input int m);
    return (m == 0) ? int'(count0) : int'(count1);
  endfunction

  // Leave the sampling point and move to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 2'b11;
    s_data[0] = 8'hEE;
    s_data[1] = 8'hEE;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      next_cycle();
    end
    rst = 1'b0;
    s_valid = 2'b00;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      total++; if (m_valid[m] !== 1'b0) begin bad++; $display("FAIL reset_m_valid[m%0d]: got %b expected 0", m, m_valid[m]); end
      total++; if (m_data[m] !== 8'h00) begin bad++; $display("FAIL reset_m_data[m%0d]: got %0h expected 00", m, m_data[m]); end
      total++; if (cnt(m) != 0) begin bad++; $display("FAIL reset_count[m%0d]: got %0d expected 0", m, cnt(m)); end
      total++; if (empty[m] !== 1'b1) begin bad++; $display("FAIL reset_empty[m%0d]: got %b expected 1", m, empty[m]); end
      total++; if (full[m] !== 1'b0) begin bad++; $display("FAIL reset_full[m%0d]: got %b expected 0", m, full[m]); end
      total++; if (s_ready[m] !== 1'b1) begin bad++; $display("FAIL reset_s_ready[m%0d]: got %b expected 1", m, s_ready[m]); end
    end
    next_cycle();
  endtask

  // 0x01..0x10 back to back with m_ready high; first output in cycle 3.
  task automatic test_stream(input int m);
    int   in_n;
    int   out_n;
    logic exp_v;
    m_ready[m] = 1'b1;
    for (int c = 0; c < 21; c++) begin
      s_valid[m] = (c < 16);
      s_data[m]  = 8'(c + 1);
      @(negedge clk);
      exp_v = (c >= 3) && (c < 19);
      in_n  = (c < 16) ? c : 16;
      out_n = (c <= 3) ? 0 : (((c < 19) ? c : 19) - 3);
      total++; if (s_ready[m] !== 1'b1) begin bad++; $display("FAIL stream_s_ready[m%0d c%0d]: got %b expected 1", m, c, s_ready[m]); end
      total++; if (m_valid[m] !== exp_v) begin bad++; $display("FAIL stream_m_valid[m%0d c%0d]: got %b expected %b", m, c, m_valid[m], exp_v); end
      if (exp_v) begin
        total++; if (m_data[m] !== 8'(c - 2)) begin bad++; $display("FAIL stream_m_data[m%0d c%0d]: got %0h expected %0h", m, c, m_data[m], 8'(c - 2)); end
      end
      total++; if (cnt(m) != in_n - out_n) begin bad++; $display("FAIL stream_count[m%0d c%0d]: got %0d expected %0d", m, c, cnt(m), in_n - out_n); end
      next_cycle();
    end
    s_valid[m] = 1'b0;
    m_ready[m] = 1'b0;
  endtask

  // Stall the output: CAP items go in, then ready drops; drain in order.
  task automatic test_backpressure(input int m);
    int   cap;
    int   acc;
    int   outn;
    logic exp_r;
    cap  = 3 + m;
    acc  = 0;
    outn = 0;
    m_ready[m] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      s_valid[m] = 1'b1;
      s_data[m]  = 8'(8'h30 + acc);
      @(negedge clk);
      exp_r = (c < cap);
      total++; if (s_ready[m] !== exp_r) begin bad++; $display("FAIL bp_s_ready[m%0d c%0d]: got %b expected %b", m, c, s_ready[m], exp_r); end
      if (s_ready[m] === 1'b1) acc++;
      next_cycle();
    end
    s_valid[m] = 1'b0;
    @(negedge clk);
    total++; if (full[m] !== 1'b1) begin bad++; $display("FAIL bp_full[m%0d]: got %b expected 1", m, full[m]); end
    total++; if (cnt(m) != cap) begin bad++; $display("FAIL bp_count[m%0d]: got %0d expected %0d", m, cnt(m), cap); end
    next_cycle();
    m_ready[m] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_valid[m] === 1'b1) begin
        total++; if (m_data[m] !== 8'(8'h30 + outn)) begin bad++; $display("FAIL bp_order[m%0d #%0d]: got %0h expected %0h", m, outn, m_data[m], 8'(8'h30 + outn)); end
        outn++;
      end
      next_cycle();
    end
    total++; if (outn != cap) begin bad++; $display("FAIL bp_drained[m%0d]: got %0d items expected %0d", m, outn, cap); end
    m_ready[m] = 1'b0;
  endtask

  // Gapped input under a stalled output must still all be accepted.
  task automatic test_bubble(input int m);
    logic [7:0] vals [3];
    int         outn;
    vals = '{8'hA1, 8'hA2, 8'hA3};
    outn = 0;
    m_ready[m] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      s_valid[m] = (c % 2 == 0);
      s_data[m]  = (c % 2 == 0) ? vals[c / 2] : 8'h00;
      @(negedge clk);
      if (c % 2 == 0) begin
        total++; if (s_ready[m] !== 1'b1) begin bad++; $display("FAIL bubble_s_ready[m%0d c%0d]: got %b expected 1", m, c, s_ready[m]); end
      end
      next_cycle();
    end
    s_valid[m] = 1'b0;
    @(negedge clk);
    total++; if (cnt(m) != 3) begin bad++; $display("FAIL bubble_count[m%0d]: got %0d expected 3", m, cnt(m)); end
    next_cycle();
    m_ready[m] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_valid[m] === 1'b1) begin
        if (outn < 3) begin
          total++; if (m_data[m] !== vals[outn]) begin bad++; $display("FAIL bubble_order[m%0d #%0d]: got %0h expected %0h", m, outn, m_data[m], vals[outn]); end
        end
        outn++;
      end
      next_cycle();
    end
    total++; if (outn != 3) begin bad++; $display("FAIL bubble_drained[m%0d]: got %0d items expected 3", m, outn); end
    m_ready[m] = 1'b0;
  endtask

  // Combinational-ready mode at full: one in and one out on the same edge.
  task automatic test_simultaneous();
    logic [7:0] exp_d [4];
    int         exp_c [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h55};
    exp_c = '{3, 3, 2, 1};
    m_ready[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      s_valid[0] = 1'b1;
      s_data[0]  = 8'(17 * (c + 1));
      @(negedge clk);
      next_cycle();
    end
    s_data[0]  = 8'h55;
    m_ready[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total++; if (s_ready[0] !== 1'b1) begin bad++; $display("FAIL simul_s_ready: got %b expected 1", s_ready[0]); end
        total++; if (full[0] !== 1'b1) begin bad++; $display("FAIL simul_full: got %b expected 1", full[0]); end
      end
      total++; if (m_valid[0] !== 1'b1) begin bad++; $display("FAIL simul_m_valid[c%0d]: got %b expected 1", c, m_valid[0]); end
      total++; if (m_data[0] !== exp_d[c]) begin bad++; $display("FAIL simul_m_data[c%0d]: got %0h expected %0h", c, m_data[0], exp_d[c]); end
      total++; if (cnt(0) != exp_c[c]) begin bad++; $display("FAIL simul_count[c%0d]: got %0d expected %0d", c, cnt(0), exp_c[c]); end
      next_cycle();
      s_valid[0] = 1'b0;
    end
    @(negedge clk);
    total++; if (empty[0] !== 1'b1) begin bad++; $display("FAIL simul_empty: got %b expected 1", empty[0]); end
    next_cycle();
    m_ready[0] = 1'b0;
  endtask

  // Two items held, then a one-cycle flush with both sides willing.
  task automatic test_flush(input int m);
    m_ready[m] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      s_valid[m] = 1'b1;
      s_data[m]  = 8'(8'h71 + c);
      @(negedge clk);
      next_cycle();
    end
    s_valid[m] = 1'b0;
    @(negedge clk);
    total++; if (cnt(m) != 2) begin bad++; $display("FAIL flush_pre_count[m%0d]: got %0d expected 2", m, cnt(m)); end
    next_cycle();
    flush[m]   = 1'b1;
    s_valid[m] = 1'b1;
    s_data[m]  = 8'h73;
    m_ready[m] = 1'b1;
    @(negedge clk);
    total++; if (s_ready[m] !== 1'b0) begin bad++; $display("FAIL flush_s_ready[m%0d]: got %b expected 0", m, s_ready[m]); end
    total++; if (m_valid[m] !== 1'b0) begin bad++; $display("FAIL flush_m_valid[m%0d]: got %b expected 0", m, m_valid[m]); end
    next_cycle();
    flush[m]   = 1'b0;
    s_valid[m] = 1'b0;
    m_ready[m] = 1'b0;
    @(negedge clk);
    total++; if (cnt(m) != 0) begin bad++; $display("FAIL flush_count[m%0d]: got %0d expected 0", m, cnt(m)); end
    total++; if (m_valid[m] !== 1'b0) begin bad++; $display("FAIL flush_post_m_valid[m%0d]: got %b expected 0", m, m_valid[m]); end
    total++; if (empty[m] !== 1'b1) begin bad++; $display("FAIL flush_empty[m%0d]: got %b expected 1", m, empty[m]); end
    total++; if (s_ready[m] !== 1'b1) begin bad++; $display("FAIL flush_post_s_ready[m%0d]: got %b expected 1", m, s_ready[m]); end
    next_cycle();
  endtask

  // rst while full with an output ready: nothing leaves, payloads cleared.
  task automatic test_reset_mid();
    m_ready[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      s_valid[0] = 1'b1;
      s_data[0]  = 8'(8'h91 + c);
      @(negedge clk);
      next_cycle();
    end
    rst        = 1'b1;
    m_ready[0] = 1'b1;
    @(negedge clk);
    total++; if (m_valid[0] !== 1'b0) begin bad++; $display("FAIL rstmid_m_valid: got %b expected 0", m_valid[0]); end
    total++; if (s_ready[0] !== 1'b0) begin bad++; $display("FAIL rstmid_s_ready: got %b expected 0", s_ready[0]); end
    next_cycle();
    rst        = 1'b0;
    s_valid[0] = 1'b0;
    m_ready[0] = 1'b0;
    @(negedge clk);
    total++; if (cnt(0) != 0) begin bad++; $display("FAIL rstmid_count: got %0d expected 0", cnt(0)); end
    total++; if (m_data[0] !== 8'h00) begin bad++; $display("FAIL rstmid_m_data: got %0h expected 00", m_data[0]); end
    total++; if (empty[0] !== 1'b1) begin bad++; $display("FAIL rstmid_empty: got %b expected 1", empty[0]); end
    next_cycle();
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    flush     = 2'b00;
    s_valid   = 2'b00;
    m_ready   = 2'b00;
    s_data[0] = 8'h00;
    s_data[1] = 8'h00;
    test_reset();
    test_stream(0);
    test_stream(1);
    test_backpressure(0);
    test_backpressure(1);
    test_bubble(0);
    test_bubble(1);
    test_simultaneous();
    test_flush(0);
    test_flush(1);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bubble_pipe.md
BUBBLE_PIPE -- requirements
Module: bubble_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of payload bits.
REQ-002 SHALL have parameter STAGES, default 3, number of pipeline register stages; legal range 1..16.
REQ-003 SHALL have parameter REG_READY, default 0; 0 = combinational ready chain, 1 = input skid buffer so s_ready comes only from a flop.
REQ-004 SHALL define CAP = STAGES + REG_READY and CW = $clog2(CAP+1).
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 flush  input  1  synchronous discard of all held items.
REQ-008 s_valid  input  1  upstream item valid.
REQ-009 s_ready  output  1  block can accept an item this cycle.
REQ-010 s_data  input  DATA_WIDTH  upstream payload.
REQ-011 m_valid  output  1  output item valid.
REQ-012 m_ready  input  1  downstream accepts this cycle.
REQ-013 m_data  output  DATA_WIDTH  output payload (last stage register).
REQ-014 count  output  CW  number of items held (stages plus skid).
REQ-015 empty  output  1  count == 0.
REQ-016 full  output  1  count == CAP.

Function
REQ-017 A transfer SHALL occur on an edge where valid & ready on the same side; data SHALL never be dropped, duplicated or reordered.
REQ-018 Each stage i SHALL hold valid_i/data_i; stage-ready r_i = r_(i+1) | ~valid_i, with r_STAGES = m_ready (bubble collapse: an empty stage accepts even when downstream stalls).
REQ-019 When r_i, valid_i SHALL load the upstream valid; data_i SHALL load only when r_i and upstream valid, otherwise hold.
REQ-020 REG_READY=0: s_ready = r_0 (combinational from m_ready through the chain).
REQ-021 REG_READY=1: s_ready = ~skid_valid; an accept while r_0 = 0 SHALL capture into the skid register; a valid skid entry SHALL feed stage 0 with priority over s_data when r_0 = 1, freeing the skid that edge.
REQ-022 REG_READY=1 with skid empty and r_0 = 1: s_data SHALL bypass the skid directly into stage 0.
REQ-023 Latency SHALL be STAGES cycles from accept edge to m_valid on an empty pipe, either mode.
REQ-024 With m_ready held 1 and s_valid held 1, throughput SHALL be one item per cycle with no gaps, either mode.
REQ-025 m_valid = valid_(STAGES-1); m_data = data_(STAGES-1).
REQ-026 count SHALL +1 on input-only transfer, -1 on output-only transfer, hold when both or neither occur; never exceed CAP nor go below 0.
REQ-027 At full with m_ready = 1 and REG_READY=0, s_ready SHALL be 1 and count SHALL hold at CAP.
REQ-028 flush SHALL force s_ready = 0 and m_valid = 0 in the flush cycle (no transfers) and clear all valid flags, skid_valid and count on that edge; data registers hold.
REQ-029 flush and rst asserted together SHALL behave as rst.

Reset
REQ-030 On rst edge: all valid_i = 0, skid_valid = 0, all data registers = 0, count = 0.
REQ-031 After reset: m_valid = 0, m_data = 0, empty = 1, full = 0, s_ready = 1 (both modes).
REQ-032 rst mid-operation SHALL discard all held items with no output transfer in the rst cycle.

Verification (DATA_WIDTH=8, STAGES=3)
REQ-033 Reset: rst high 2 cycles with s_valid = 1 -> m_valid = 0, m_data = 0x00, count = 0, empty = 1, s_ready = 1 after release.
REQ-034 Stream: m_ready = 1, push 0x01..0x10 back-to-back -> 0x01 on m_data 3 cycles after first accept, then one per cycle in order, count steady at 3, no s_ready drop (both modes).
REQ-035 Backpressure: m_ready = 0, s_valid = 1 -> accepts 3 items (REG_READY=0) or 4 (REG_READY=1), then s_ready = 0, full = 1; m_ready = 1 -> all items out in order.
REQ-036 Bubble collapse: m_ready = 0, s_valid pattern 1,0,1,0,1 carrying 0xA1,0xA2,0xA3 -> all 3 accepted, count = 3, output order 0xA1,0xA2,0xA3 once released.
REQ-037 Simultaneous: REG_READY=0, full, m_ready = 1, s_valid = 1 with 0x55 -> one in, one out same edge, count stays 3, 0x55 emerges 3 cycles later.
REQ-038 Flush: count = 2, pulse flush 1 cycle with s_valid = m_ready = 1 -> no transfer that cycle, next cycle count = 0, m_valid = 0, empty = 1, s_ready = 1.
